// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: one 8-byte-lane bus request per op, load align/extend, valid/ready to writeback.
// Optional: YSYX_22040088_LSU_MISALIGN_CHECK_EN faults misaligned accesses instead of aligning them down.
module ysyx_22040088_lsu #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mem_ena,
  input  logic          mem_wen,
  input  logic [3:0]    mem_mask,
  input  logic [1:0]    sel_memdata,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] rdata,
  output logic          out_err,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic [AW-1:0] bus_addr,
  output logic          bus_wen,
  output logic [DW-1:0] bus_wdata,
  output logic [7:0]    bus_wstrb,
  input  logic          bus_resp_valid,
  output logic          bus_resp_ready,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    op_mask;
  logic          op_wen;
  logic [1:0]    op_sel;
  logic [2:0]    op_off;
  logic [2:0]    amask, off;
  logic [7:0]    lane_ones;
  logic          onehot, misalign, fault;
  logic [DW-1:0] raw, load_val;

  // amask keeps the offset bits that are legal for the access size
  always_comb begin
    amask     = 3'b111;
    lane_ones = 8'h01;
    case (mem_mask)
      4'b0001: begin amask = 3'b000; lane_ones = 8'hFF; end
      4'b0010: begin amask = 3'b100; lane_ones = 8'h0F; end
      4'b0100: begin amask = 3'b110; lane_ones = 8'h03; end
      default: begin amask = 3'b111; lane_ones = 8'h01; end
    endcase
  end

  assign onehot = (mem_mask == 4'b0001) || (mem_mask == 4'b0010) ||
                  (mem_mask == 4'b0100) || (mem_mask == 4'b1000);

`ifdef YSYX_22040088_LSU_MISALIGN_CHECK_EN
  assign misalign = |(addr[2:0] & ~amask);
  assign off      = addr[2:0];
`else
  assign misalign = 1'b0;
  assign off      = addr[2:0] & amask;
`endif

  assign fault = !onehot || misalign;

  assign in_ready       = (state == IDLE);
  assign bus_req_valid  = (state == REQ);
  assign bus_resp_ready = (state == RESP);
  assign out_valid      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = (!mem_ena || fault) ? DONE : REQ;
      REQ:     if (bus_req_ready)  state_nxt = RESP;
      RESP:    if (bus_resp_valid) state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend by size
  assign raw = bus_rdata >> {op_off, 3'b000};

  always_comb begin
    load_val = raw;
    case (op_mask)
      4'b0010: load_val = (!op_sel[1] && op_sel[0]) ? {{32{raw[31]}}, raw[31:0]} : {32'b0, raw[31:0]};
      4'b0100: load_val = (!op_sel[1] && op_sel[0]) ? {{48{raw[15]}}, raw[15:0]} : {48'b0, raw[15:0]};
      4'b1000: load_val = (!op_sel[1] && op_sel[0]) ? {{56{raw[7]}},  raw[7:0]}  : {56'b0, raw[7:0]};
      default: load_val = raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_mask   <= '0;
      op_wen    <= 1'b0;
      op_sel    <= '0;
      op_off    <= '0;
      rdata     <= '0;
      out_err   <= 1'b0;
      bus_addr  <= '0;
      bus_wen   <= 1'b0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_mask <= mem_mask;
          op_wen  <= mem_wen;
          op_sel  <= sel_memdata;
          op_off  <= off;
          rdata   <= '0;
          out_err <= mem_ena && fault;
          // request fields only change on a real bus op, so they stay put through REQ
          if (mem_ena && !fault) begin
            bus_addr  <= {addr[AW-1:3], 3'b000};
            bus_wen   <= mem_wen;
            bus_wdata <= wdata << {off, 3'b000};
            bus_wstrb <= lane_ones << off;
          end
        end
        RESP: if (bus_resp_valid) begin
          out_err <= bus_resp_err;
          rdata   <= op_wen ? '0 : load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Bench for ysyx_22040088_lsu: directed vector table, reset corner case, random ops vs a reference model.
// Honors YSYX_22040088_LSU_MISALIGN_CHECK_EN when computing expectations.
module tb_ysyx_22040088_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, mem_ena, mem_wen;
  logic [3:0]  mem_mask;
  logic [1:0]  sel_memdata;
  logic [63:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic        out_valid, out_ready, out_err;
  logic        bus_req_valid, bus_req_ready, bus_wen;
  logic [7:0]  bus_wstrb;
  logic        bus_resp_valid, bus_resp_ready, bus_resp_err;

  always #5 clk = ~clk;

  ysyx_22040088_lsu #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_mask(mem_mask), .sel_memdata(sel_memdata),
    .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .rdata(rdata), .out_err(out_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready),
    .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
  );

  typedef struct {
    logic        ena, wen;
    logic [3:0]  mask;
    logic [1:0]  sel;
    logic [63:0] addr, wdata, brdata;
    logic        berr;
    int          rw, sw, ow;     // bus_req_ready delay, response delay, out_ready delay
    logic [63:0] e_rdata;
    logic        e_err, e_req;
    logic [63:0] e_addr;
    logic [7:0]  e_wstrb;
    logic [63:0] e_wdata;
  } vec_t;

  int passed = 0;
  int total  = 0;
  vec_t tbl[11];

  logic [63:0] g_rdata, g_addr, g_wdata;
  logic        g_err, g_wen, g_req;
  logic [7:0]  g_wstrb;
  int          g_req_cyc, g_out_cyc;
  bit          g_req_unst, g_out_unst, g_ir_bad, g_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Reference model: what the op should produce, from sizes and byte offsets
  function automatic vec_t model(input vec_t v);
    int size, off;
    logic [63:0] lmask, r;
    v.e_req = 1'b0; v.e_err = 1'b0; v.e_rdata = '0;
    v.e_addr = '0; v.e_wstrb = '0; v.e_wdata = '0;
    if (!v.ena) return v;
    case (v.mask)
      4'b0001: size = 8;
      4'b0010: size = 4;
      4'b0100: size = 2;
      4'b1000: size = 1;
      default: size = 0;
    endcase
    if (size == 0) begin v.e_err = 1'b1; return v; end
    off = int'(v.addr % 64'd8);
`ifdef YSYX_22040088_LSU_MISALIGN_CHECK_EN
    if (v.addr % 64'(size) != 64'd0) begin v.e_err = 1'b1; return v; end
`else
    off = off - (off % size);
`endif
    v.e_req   = 1'b1;
    v.e_addr  = v.addr - (v.addr % 64'd8);
    v.e_wstrb = 8'((((1 << size) - 1) << off) & 255);
    v.e_wdata = v.wdata << (8 * off);
    v.e_err   = v.berr;
    if (!v.wen) begin
      lmask = (size == 8) ? '1 : (64'd1 << (8 * size)) - 64'd1;
      r = (v.brdata >> (8 * off)) & lmask;
      if (size != 8 && !v.sel[1] && v.sel[0] && r[8*size-1]) r = r | ~lmask;
      v.e_rdata = r;
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int rc, sc, oc;
    rc = 0; sc = 0; oc = 0;
    g_req = 1'b0; g_req_cyc = -1; g_out_cyc = -1;
    g_req_unst = 0; g_out_unst = 0; g_ir_bad = 0; g_done = 0;
    @(negedge clk);
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; out_ready = 1'b0;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; mem_ena = v.ena; mem_wen = v.wen; mem_mask = v.mask;
    sel_memdata = v.sel; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    for (int n = 1; n < 40 && !g_done; n++) begin
      @(negedge clk);
      // scramble the op inputs: the DUT must work from what it latched
      in_valid = 1'b0; mem_ena = 1'($urandom); mem_wen = 1'($urandom);
      mem_mask = 4'($urandom); sel_memdata = 2'($urandom);
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; out_ready = 1'b0;
      bus_rdata = {$urandom, $urandom}; bus_resp_err = 1'($urandom);
      if (in_ready) g_ir_bad = 1;
      if (bus_req_valid) begin
        if (!g_req) begin
          g_req = 1'b1; g_req_cyc = n;
          g_addr = bus_addr; g_wen = bus_wen; g_wdata = bus_wdata; g_wstrb = bus_wstrb;
        end else if (bus_addr !== g_addr || bus_wen !== g_wen ||
                     bus_wdata !== g_wdata || bus_wstrb !== g_wstrb) g_req_unst = 1;
        bus_resp_valid = 1'($urandom);   // stray response, must be ignored
        if (rc == v.rw) bus_req_ready = 1'b1;
        rc++;
      end
      if (bus_resp_ready) begin
        if (sc == v.sw) begin
          bus_resp_valid = 1'b1; bus_rdata = v.brdata; bus_resp_err = v.berr;
        end
        sc++;
      end
      if (out_valid) begin
        if (oc == 0) begin g_out_cyc = n; g_rdata = rdata; g_err = out_err; end
        else if (rdata !== g_rdata || out_err !== g_err) g_out_unst = 1;
        if (oc == v.ow) begin out_ready = 1'b1; g_done = 1; end
        oc++;
      end
    end
    if (g_done) @(posedge clk);
  endtask

  task automatic check_vec(input string t, input vec_t v);
    run_op(v);
    chk({t, "_done"}, 64'(g_done), 64'd1);
    if (g_done) begin
      chk({t, "_rdata"}, g_rdata, v.e_rdata);
      chk({t, "_err"}, 64'(g_err), 64'(v.e_err));
      chk({t, "_req"}, 64'(g_req), 64'(v.e_req));
      chk({t, "_out_cyc"}, 64'(g_out_cyc), v.e_req ? 64'(3 + v.rw + v.sw) : 64'd1);
      chk({t, "_out_stable"}, 64'(g_out_unst), 64'd0);
      chk({t, "_in_ready_low"}, 64'(g_ir_bad), 64'd0);
      if (v.e_req && g_req) begin
        chk({t, "_req_cyc"}, 64'(g_req_cyc), 64'd1);
        chk({t, "_bus_addr"}, g_addr, v.e_addr);
        chk({t, "_bus_wen"}, 64'(g_wen), 64'(v.wen));
        chk({t, "_bus_wstrb"}, 64'(g_wstrb), 64'(v.e_wstrb));
        chk({t, "_bus_wdata"}, g_wdata, v.e_wdata);
        chk({t, "_req_stable"}, 64'(g_req_unst), 64'd0);
      end
    end
  endtask

  initial begin
    vec_t v;
    // ena wen mask sel addr wdata brdata berr rw sw ow | rdata err req bus_addr wstrb wdata
    tbl[0] = '{1'b1, 1'b0, 4'b1000, 2'b01, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 0,
               64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1, 64'h8000_0000, 8'h08, 64'h0};
    tbl[1] = '{1'b1, 1'b0, 4'b0100, 2'b10, 64'h6, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 0, 0, 0,
               64'h0000_0000_0000_BEEF, 1'b0, 1'b1, 64'h0, 8'hC0, 64'h0};
    tbl[2] = '{1'b1, 1'b1, 4'b0010, 2'b00, 64'h4, 64'h1122_3344, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 0, 0, 0,
               64'h0, 1'b0, 1'b1, 64'h0, 8'hF0, 64'h1122_3344_0000_0000};
    tbl[3] = '{1'b1, 1'b0, 4'b0001, 2'b01, 64'h1000, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1, 2,
               64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 64'h1000, 8'hFF, 64'h0};
    tbl[4] = '{1'b1, 1'b0, 4'b0001, 2'b01, 64'h2000, 64'h0, 64'h0, 1'b1, 0, 0, 0,
               64'h0, 1'b1, 1'b1, 64'h2000, 8'hFF, 64'h0};
    tbl[5] = '{1'b1, 1'b0, 4'b0011, 2'b01, 64'h10, 64'h0, 64'h0, 1'b0, 0, 0, 0,
               64'h0, 1'b1, 1'b0, 64'h0, 8'h00, 64'h0};
    tbl[6] = '{1'b0, 1'b0, 4'b0001, 2'b01, 64'h18, 64'h55, 64'h77, 1'b0, 0, 0, 1,
               64'h0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0};
`ifdef YSYX_22040088_LSU_MISALIGN_CHECK_EN
    tbl[7] = '{1'b1, 1'b0, 4'b0010, 2'b01, 64'h2, 64'h0, 64'h0000_0000_8000_0001, 1'b0, 0, 0, 0,
               64'h0, 1'b1, 1'b0, 64'h0, 8'h00, 64'h0};
`else
    tbl[7] = '{1'b1, 1'b0, 4'b0010, 2'b01, 64'h2, 64'h0, 64'h0000_0000_8000_0001, 1'b0, 0, 0, 0,
               64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1, 64'h0, 8'h0F, 64'h0};
`endif
    tbl[8] = '{1'b1, 1'b0, 4'b1000, 2'b10, 64'h7, 64'h0, 64'hAB00_0000_0000_0000, 1'b0, 1, 2, 0,
               64'h0000_0000_0000_00AB, 1'b0, 1'b1, 64'h0, 8'h80, 64'h0};
    tbl[9] = '{1'b1, 1'b1, 4'b0100, 2'b01, 64'h6, 64'hFFFF_FFFF_FFFF_A5A5, 64'h1234, 1'b0, 0, 0, 0,
               64'h0, 1'b0, 1'b1, 64'h0, 8'hC0, 64'hA5A5_0000_0000_0000};
    tbl[10] = '{1'b1, 1'b0, 4'b0100, 2'b01, 64'h2, 64'h0, 64'h0000_0000_8001_0000, 1'b0, 0, 0, 0,
                64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b1, 64'h0, 8'h0C, 64'h0};

    rst_n = 1'b0; in_valid = 1'b0; mem_ena = 1'b0; mem_wen = 1'b0; mem_mask = '0;
    sel_memdata = '0; addr = '0; wdata = '0; out_ready = 1'b0; bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0; bus_rdata = '0; bus_resp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(bus_req_valid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_bus_wstrb", 64'(bus_wstrb), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) check_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset while waiting for the bus response
    @(negedge clk);
    in_valid = 1'b1; mem_ena = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0001;
    sel_memdata = 2'b01; addr = 64'h40; bus_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("mid_resp_ready", 64'(bus_resp_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_resp_ready", 64'(bus_resp_ready), 64'd0);
    chk("mid_rst_rdata", rdata, 64'd0);
    chk("mid_rst_err", 64'(out_err), 64'd0);
    chk("mid_rst_bus_addr", bus_addr, 64'd0);
    chk("mid_rst_bus_wstrb", 64'(bus_wstrb), 64'd0);
    chk("mid_rst_bus_wdata", bus_wdata, 64'd0);
    chk("mid_rst_bus_wen", 64'(bus_wen), 64'd0);
    bus_resp_valid = 1'b1; bus_rdata = 64'h1111; bus_resp_err = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_resp_ignored", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    bus_resp_valid = 1'b0;
    check_vec("post_rst_pass", tbl[6]);

    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      v.ena    = ($urandom_range(0, 7) != 0);
      v.wen    = 1'($urandom);
      v.mask   = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
      v.sel    = 2'($urandom);
      v.addr   = {$urandom, $urandom};
      v.wdata  = {$urandom, $urandom};
      v.brdata = {$urandom, $urandom};
      v.berr   = ($urandom_range(0, 5) == 0);
      v.rw     = int'($urandom_range(0, 3));
      v.sw     = int'($urandom_range(0, 3));
      v.ow     = int'($urandom_range(0, 2));
      v = model(v);
      check_vec($sformatf("rnd%0d", i), v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
